mips32_dmem_responder: RTL

- Memory-side responder for the pipelined MIPS32 core's data path.
- Serves the single-word LW/SW requests issued from the MEM stage over a valid/ready request and response handshake.
- Owns a DEPTH x 32 word-addressed array and inserts a programmable number of wait states.
- Replaces the core's directly indexed data memory so the pipeline can be tested against slow memory.

---
 rtl/mips32_dmem_responder_if.sv | 26 ++
 rtl/mips32_dmem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mips32_dmem_responder_if.sv
// mips32_dmem_responder_if
// Request/response handshake between the MIPS32 MEM stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake; req_we, req_addr, req_wdata ride with it
//   resp_valid/resp_ready : response handshake; resp_rdata, resp_err ride with it
interface mips32_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mips32_dmem_responder.sv
// mips32_dmem_responder
// Word-addressed DEPTH x 32 data memory that answers single-word LW/SW
// requests after WAIT_CYCLES wait states, with an out-of-range error flag.
//   clk, rst_n          : system clock, async active-low reset
//   bus (slave)         : request/response handshake
//   dbg_addr/dbg_rdata  : combinational backdoor read of the array
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | request held, counting down wait states; access when count is 0
// RESP   | response presented, waiting for resp_ready
module mips32_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips32_dmem_responder_if.slave bus,
  input  logic [AW-1:0]          dbg_addr,
  output logic [31:0]            dbg_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [32:0] DEPTH_W   = 33'(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];
  logic        in_range;
  logic        mem_we;

  // Full 32-bit compare so high address bits never alias into the array.
  assign in_range = ({1'b0, addr_q} < DEPTH_W);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
          if (!in_range) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we  = 1'b1;
            rdata_d = 32'd0;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem[addr_q[AW-1:0]];
            err_d   = 1'b0;
          end
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Array is not reset; mem_we is gated by state_q, so an async reset during
  // WAIT cancels a pending store before its access edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_rdata      = mem[dbg_addr];

endmodule
